vga_fb_fetch_ctrl: RTL and testbench

//   Sequences framebuffer reads that refill the 24-bit pixel FIFO drained by the VGA timing block.

---
 rtl/vga_fb_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_vga_fb_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_fetch_ctrl.sv
// Framebuffer fetch controller: refills the VGA pixel FIFO from a shared single-port SRAM,
// arbitrating against one writer and restarting the pixel stream on every vsync fall.
module vga_fb_fetch_ctrl #(
   parameter int unsigned H_ACT      = 640,
   parameter int unsigned V_ACT      = 480,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned LVL_W      = 7,
   parameter int unsigned LOW_WM     = 16,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic [LVL_W-1:0]  fifo_level,
   output logic              fifo_wr_en,
   output logic [23:0]       fifo_din,
   output logic              fifo_flush,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   output logic              wr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [23:0]       mem_wdata,
   input  logic [23:0]       mem_rdata,
   output logic              frame_err
);

   localparam int unsigned TOTAL = H_ACT * V_ACT;
   localparam int unsigned PTR_W = $clog2(TOTAL);
   localparam int unsigned CNT_W = LVL_W + 1;

   typedef enum logic [1:0] {StWaitVs, StFetch, StDone, StResync} state_e;

   state_e            state_q, state_d;
   logic              vs_q1, vs_q2, vs_start;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  inflight_q;
   logic [RD_LAT-1:0] vpipe_q;
   logic [CNT_W-1:0]  occupancy;
   logic [ADDR_W-1:0] rd_addr;
   logic              credit, urgent, wr_ok, last_rd, exit_tag;
   logic              issue_rd, issue_wr, flush_d, err_d, ptr_clr;

   assign vs_start  = vs_q2 & ~vs_q1;
   // inflight counts reads from the arbitration decision until their data leaves the pipe
   assign occupancy = CNT_W'(fifo_level) + inflight_q;
   assign credit    = occupancy < CNT_W'(FIFO_DEPTH);
   assign last_rd   = rd_ptr_q == PTR_W'(TOTAL - 1);
   assign exit_tag  = vpipe_q[RD_LAT-1];
   assign rd_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_ptr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StWaitVs;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StWaitVs, StDone: if (vs_start) state_d = StFetch;
         StFetch: begin
            if (vs_start)                 state_d = StResync;
            else if (issue_rd && last_rd) state_d = StDone;
         end
         StResync: if (inflight_q == '0) state_d = StFetch;
         default: state_d = StWaitVs;
      endcase
   end

   always_comb begin
      urgent     = (state_q == StFetch) && (occupancy < CNT_W'(LOW_WM)) && credit;
      // mask the request during its own ack cycle so a held wr_req is not written twice
      wr_ok      = wr_req && !wr_ack;
      issue_rd   = urgent || ((state_q == StFetch) && credit && !wr_ok);
      issue_wr   = wr_ok && !urgent;
      flush_d    = ((state_q == StWaitVs) && vs_start) ||
                   ((state_q == StResync) && (inflight_q == '0));
      err_d      = (state_q == StFetch) && vs_start;
      ptr_clr    = (state_q != StFetch) && (state_d == StFetch);
      fifo_wr_en = exit_tag && (state_q != StResync);
      fifo_din   = fifo_wr_en ? mem_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q1      <= 1'b0;
         vs_q2      <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         wr_ack     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         fifo_flush <= 1'b0;
         frame_err  <= 1'b0;
         rd_ptr_q   <= '0;
         inflight_q <= '0;
         vpipe_q    <= '0;
      end else begin
         vs_q1      <= vsync;
         vs_q2      <= vs_q1;
         mem_en     <= issue_rd | issue_wr;
         mem_we     <= issue_wr;
         wr_ack     <= issue_wr;
         fifo_flush <= flush_d;
         frame_err  <= err_d;
         if (issue_wr) begin
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
         end else if (issue_rd) begin
            mem_addr  <= rd_addr;
         end
         if (ptr_clr)       rd_ptr_q <= '0;
         else if (issue_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         inflight_q <= inflight_q + CNT_W'(issue_rd) - CNT_W'(exit_tag);
         vpipe_q    <= RD_LAT'({vpipe_q, mem_en & ~mem_we});
      end
   end

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// Scoreboard bench for vga_fb_fetch_ctrl: a latency-accurate SRAM model feeds pixels, expected
// pixels are queued at read issue and compared when the controller writes the FIFO.
module tb_vga_fb_fetch_ctrl;

   localparam int H_ACT  = 32;
   localparam int V_ACT  = 16;
   localparam int TOTAL  = H_ACT * V_ACT;
   localparam int ADDR_W = 19;
   localparam int BASE   = 256;
   localparam int DEPTH  = 64;
   localparam int LVL_W  = 7;
   localparam int LOW_WM = 16;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              vsync = 1'b1;
   logic [LVL_W-1:0]  fifo_level = '0;
   logic              fifo_wr_en, fifo_flush, wr_ack, mem_en, mem_we, frame_err;
   logic [23:0]       fifo_din, mem_wdata, mem_rdata;
   logic              wr_req = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [23:0]       wr_data = '0;
   logic [ADDR_W-1:0] mem_addr;

   vga_fb_fetch_ctrl #(
      .H_ACT(H_ACT), .V_ACT(V_ACT), .ADDR_W(ADDR_W), .BASE_ADDR(BASE),
      .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W), .LOW_WM(LOW_WM), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vsync(vsync), .fifo_level(fifo_level),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_flush(fifo_flush),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int exp_idx = 0, out_prev = 0, cur = 0, cur_prev = 0, out_max = 0;
   int rd_cnt = 0, wr_cnt = 0, fwe_cnt = 0, flush_cnt = 0, ferr_cnt = 0;
   int flush_cyc = 0, ferr_cyc = 0, first_en = -1, first_wr = -1;
   int fall, k, rd0, wr0, fwe0, flush0, ferr0;
   bit discarding = 0;
   logic [ADDR_W-1:0] last_rd_addr = '0, first_addr = '0;
   logic [23:0] sb[$];
   logic [23:0] exp_pix;

   function automatic logic [23:0] pat(input logic [ADDR_W-1:0] a);
      return {a[11:0], ~a[11:0]} ^ 24'h5A3C96;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // SRAM model: data for a read on the bus appears RD_LAT cycles later
   logic [RD_LAT-1:0] mv;
   logic [23:0]       md [RD_LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mv <= '0;
      else begin
         mv[0] <= mem_en && !mem_we;
         md[0] <= pat(mem_addr);
         for (int i = 1; i < RD_LAT; i++) begin
            mv[i] <= mv[i-1];
            md[i] <= md[i-1];
         end
      end
   end
   assign mem_rdata = mv[RD_LAT-1] ? md[RD_LAT-1] : 24'hDEAD00;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         discarding = 0;
         out_prev   = 0;
         cur_prev   = 0;
      end else begin
         check("ack_is_write", 32'(wr_ack), 32'(mem_en && mem_we));
         if (frame_err) begin
            ferr_cnt++;
            ferr_cyc   = cyc;
            discarding = 1;
            sb.delete();
         end
         if (fifo_flush) begin
            flush_cnt++;
            flush_cyc = cyc;
            if (discarding) check("flush_inflight", 32'(cur_prev), 0);
            discarding = 0;
            exp_idx    = 0;
         end
         cur = out_prev + ((mem_en && !mem_we) ? 1 : 0);
         if (cur > out_max) out_max = cur;
         if (fifo_wr_en) fwe_cnt++;
         if (discarding) check("resync_no_wr", 32'(fifo_wr_en), 0);
         else begin
            check("wr_align", 32'(fifo_wr_en), 32'(mv[RD_LAT-1]));
            if (fifo_wr_en) begin
               check("sb_nonempty", 32'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  exp_pix = sb.pop_front();
                  check("pixel", 32'(fifo_din), 32'(exp_pix));
               end
               if (first_wr < 0) first_wr = cyc;
            end
         end
         if (mem_en && !mem_we) begin
            rd_cnt++;
            last_rd_addr = mem_addr;
            if (first_en < 0) begin
               first_en   = cyc;
               first_addr = mem_addr;
            end
            if (!discarding) begin
               check("rd_addr", 32'(mem_addr), 32'(BASE + exp_idx));
               sb.push_back(pat(mem_addr));
               exp_idx++;
            end
         end
         if (mem_en && mem_we) wr_cnt++;
         cur_prev = cur;
         out_prev = cur - (mv[RD_LAT-1] ? 1 : 0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      vsync = 1'b0;
      fall  = cyc;
      tick(4);
      vsync = 1'b1;
   endtask

   task automatic wait_idx(input int target, input string tag);
      k = 0;
      while (exp_idx < target && k < 1500) begin
         tick(1);
         k++;
      end
      check(tag, 32'(exp_idx >= target), 1);
   endtask

   task automatic single_write(input string tag, input logic [ADDR_W-1:0] a,
                               input logic [23:0] d);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      tick(1);
      check({tag, "_ack"}, {wr_ack, mem_en, mem_we}, 3'b111);
      check({tag, "_addr"}, 32'(mem_addr), 32'(a));
      check({tag, "_data"}, 32'(mem_wdata), 32'(d));
      tick(1);
      check({tag, "_once"}, 32'(wr_ack), 0);
      wr_req = 1'b0;
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      check("rst_outs", 32'({mem_en, mem_we, wr_ack, fifo_wr_en, fifo_flush, frame_err,
                              mem_addr}), 0);
      check("rst_din", 32'(fifo_din), 0);
      tick(5);
      check("wait_idle", 32'(rd_cnt), 0);
      single_write("wait_wr", 19'h7000, 24'h123456);

      // first frame: flush, then back-to-back reads with fixed latency
      exp_idx = 0; first_en = -1; first_wr = -1; flush0 = flush_cnt;
      vs_pulse();
      k = 0;
      while (first_wr < 0 && k < 30) begin tick(1); k++; end
      check("t1_flush_cnt", 32'(flush_cnt - flush0), 1);
      check("t1_flush_cyc", 32'(flush_cyc), 32'(fall + 2));
      check("t1_first_rd", 32'(first_en), 32'(flush_cyc + 1));
      check("t1_first_addr", 32'(first_addr), 32'(BASE));
      check("t1_latency", 32'(first_wr - first_en), 32'(RD_LAT));
      wait_idx(20, "t1_progress");

      // credit limiting
      fifo_level = 7'd60;
      tick(8); out_max = 0; tick(30);
      check("t2_max60", 32'(out_max <= DEPTH - 60), 1);
      fifo_level = 7'd62;
      tick(8); out_max = 0; rd0 = rd_cnt; tick(30);
      check("t2_max62", 32'(out_max), 2);
      check("t2_throttled", 32'(rd_cnt - rd0 < 30), 1);
      check("t2_progress", 32'(rd_cnt - rd0 > 0), 1);

      // writer vs display arbitration
      fifo_level = 7'd40;
      tick(4);
      wr0 = wr_cnt;
      single_write("t3_wr", 19'h70A5, 24'hC0FFEE);
      fifo_level = 7'd10;
      wr_req = 1'b1; wr_addr = 19'h70B6; wr_data = 24'hBEEF01;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("t3_urgent_rd", {wr_ack, mem_en, mem_we}, 3'b010);
      end
      fifo_level = 7'd40;
      k = 0;
      while (!wr_ack && k < 5) begin tick(1); k++; end
      check("t3_late_ack", 32'(wr_ack), 1);
      check("t3_late_addr", 32'(mem_addr), 32'h70B6);
      tick(1);
      wr_req = 1'b0;
      tick(2);
      check("t3_wr_count", 32'(wr_cnt - wr0), 2);

      // complete frame, then idle in DONE
      fifo_level = '0;
      wait_idx(TOTAL, "t4_complete");
      check("t4_last_addr", 32'(last_rd_addr), 32'(BASE + TOTAL - 1));
      rd0 = rd_cnt;
      tick(20);
      check("t4_done_idle", 32'(rd_cnt - rd0), 0);
      single_write("t4_done_wr", 19'h7100, 24'h0A0B0C);

      // early vsync: error, discard, flush, restart
      exp_idx = 0;
      vs_pulse();
      wait_idx(40, "t5_start");
      ferr0 = ferr_cnt; flush0 = flush_cnt;
      vs_pulse();
      k = 0;
      while (flush_cnt == flush0 && k < 30) begin tick(1); k++; end
      first_en = -1;
      check("t5_ferr", 32'(ferr_cnt - ferr0), 1);
      check("t5_flush", 32'(flush_cnt - flush0), 1);
      check("t5_order", 32'(flush_cyc > ferr_cyc), 1);
      tick(3);
      check("t5_restart_cyc", 32'(first_en), 32'(flush_cyc + 1));
      check("t5_restart_addr", 32'(first_addr), 32'(BASE));
      wait_idx(TOTAL, "t5_complete");

      // reset in the middle of a fetch
      exp_idx = 0;
      vs_pulse();
      wait_idx(30, "t6_start");
      rst_n = 1'b0;
      #1;
      check("t6_rst_outs", 32'({mem_en, mem_we, wr_ack, fifo_wr_en, fifo_flush, frame_err,
                                 mem_addr}), 0);
      tick(2);
      rst_n = 1'b1;
      rd0 = rd_cnt; fwe0 = fwe_cnt;
      tick(15);
      check("t6_no_wr", 32'(fwe_cnt - fwe0), 0);
      check("t6_no_rd", 32'(rd_cnt - rd0), 0);
      exp_idx = 0;
      vs_pulse();
      wait_idx(10, "t6_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
